// File: rtl/fa_ctrl_pkg.sv
// Shared types and defaults for the single-precision adder sequencer.
// Strobe decode lives here so the state-to-output mapping is in one place.
package fa_ctrl_pkg;

    localparam int unsigned ALIGN_LIMIT_DEF = 26;
    localparam int unsigned TMR_W_DEF       = 5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        PREP  = 3'd2,
        ALIGN = 3'd3,
        SUM   = 3'd4,
        NORM  = 3'd5,
        DONE  = 3'd6
    } stateT;

    typedef struct packed {
        logic ldS1;
        logic ldS2;
        logic ldExp1;
        logic ldExp2;
        logic ldM1;
        logic ldM2;
        logic ldRegA;
        logic ldRegB;
        logic ldC;
        logic ldRegS;
        logic ldFM;
        logic busy;
        logic done;
    } strobesT;

    function automatic strobesT strobesFor(stateT s);
        strobesT r;
        r = '0;
        r.busy = (s != IDLE);
        case (s)
            LOAD: begin
                r.ldS1   = 1'b1;
                r.ldS2   = 1'b1;
                r.ldExp1 = 1'b1;
                r.ldExp2 = 1'b1;
                r.ldM1   = 1'b1;
                r.ldM2   = 1'b1;
            end
            PREP: begin
                r.ldRegA = 1'b1;
                r.ldRegB = 1'b1;
                r.ldC    = 1'b1;
            end
            SUM:     r.ldRegS = 1'b1;
            NORM:    r.ldFM   = 1'b1;
            DONE:    r.done   = 1'b1;
            default: ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/float_adder_controller_if.sv
// Handshake and strobe bundle between the adder sequencer and its datapath/consumer.
interface float_adder_controller_if;

    logic start;
    logic ack;
    logic complete;
    logic ovFlag;
    logic ldS1, ldS2, ldExp1, ldExp2, ldM1, ldM2;
    logic ldRegA, ldRegB, ldC;
    logic shEn, cntEn;
    logic ldRegS;
    logic ldFM;
    logic OV;
    logic busy;
    logic done;
    logic alignSat;

    modport master (
        input  start, ack, complete, ovFlag,
        output ldS1, ldS2, ldExp1, ldExp2, ldM1, ldM2,
        output ldRegA, ldRegB, ldC, shEn, cntEn, ldRegS, ldFM,
        output OV, busy, done, alignSat
    );

    modport slave (
        output start, ack, complete, ovFlag,
        input  ldS1, ldS2, ldExp1, ldExp2, ldM1, ldM2,
        input  ldRegA, ldRegB, ldC, shEn, cntEn, ldRegS, ldFM,
        input  OV, busy, done, alignSat
    );

endinterface

// File: rtl/fa_align_timer.sv
// Align-phase watchdog: counts ALIGN cycles and flags the last permitted one.
module fa_align_timer
    import fa_ctrl_pkg::*;
#(
    parameter int unsigned ALIGN_LIMIT = ALIGN_LIMIT_DEF,
    parameter int unsigned TMR_W       = TMR_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic limit
);

    logic [TMR_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + TMR_W'(1);
        end
    end

    assign limit = (count == TMR_W'(ALIGN_LIMIT - 1));

endmodule

// File: rtl/float_adder_controller.sv
// Sequencer for the single-precision adder datapath: load, prep, align, sum, normalise, hold result.
module float_adder_controller
    import fa_ctrl_pkg::*;
#(
    parameter int unsigned ALIGN_LIMIT = ALIGN_LIMIT_DEF,
    parameter int unsigned TMR_W       = TMR_W_DEF
) (
    input logic                        clk,
    input logic                        rst,
    float_adder_controller_if.master   bus
);

    stateT   state;
    stateT   nextState;
    strobesT strb;
    logic    ovReg;
    logic    alignSat;
    logic    limit;

    fa_align_timer #(
        .ALIGN_LIMIT (ALIGN_LIMIT),
        .TMR_W       (TMR_W)
    ) alignTimer (
        .clk   (clk),
        .rst   (rst),
        .clr   (state == PREP),
        .en    (state == ALIGN),
        .limit (limit)
    );

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (bus.start) nextState = LOAD;
            LOAD:    nextState = PREP;
            PREP:    nextState = ALIGN;
            ALIGN:   if (bus.complete || limit) nextState = SUM;
            SUM:     nextState = NORM;
            NORM:    nextState = DONE;
            DONE:    if (bus.ack) nextState = bus.start ? LOAD : IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Strobes are registered from the next-state decode so they line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            strb     <= '0;
            ovReg    <= 1'b0;
            alignSat <= 1'b0;
        end else begin
            state <= nextState;
            strb  <= strobesFor(nextState);
            if (state == LOAD) begin
                alignSat <= 1'b0;
                ovReg    <= 1'b0;
            end
            if (state == ALIGN && !bus.complete && limit) begin
                alignSat <= 1'b1;
            end
            if (state == NORM) begin
                ovReg <= bus.ovFlag;
            end
        end
    end

    assign bus.ldS1     = strb.ldS1;
    assign bus.ldS2     = strb.ldS2;
    assign bus.ldExp1   = strb.ldExp1;
    assign bus.ldExp2   = strb.ldExp2;
    assign bus.ldM1     = strb.ldM1;
    assign bus.ldM2     = strb.ldM2;
    assign bus.ldRegA   = strb.ldRegA;
    assign bus.ldRegB   = strb.ldRegB;
    assign bus.ldC      = strb.ldC;
    assign bus.ldRegS   = strb.ldRegS;
    assign bus.ldFM     = strb.ldFM;
    assign bus.busy     = strb.busy;
    assign bus.done     = strb.done;
    assign bus.alignSat = alignSat;

    // Shift/count follow complete combinationally; masked during reset so no shift leaks out.
    assign bus.shEn  = (state == ALIGN) && !bus.complete && !rst;
    assign bus.cntEn = (state == ALIGN) && !bus.complete && !rst;

    assign bus.OV = (state == NORM) ? bus.ovFlag :
                    (state == DONE) ? ovReg      : 1'b0;

endmodule

// File: tb/tb_float_adder_controller.sv
// Directed bench for the adder sequencer with a behavioural alignment-counter datapath.
module tb_float_adder_controller;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   dCur;
    int   cnt;

    float_adder_controller_if bus ();

    float_adder_controller #(
        .ALIGN_LIMIT (26),
        .TMR_W       (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath counter: preset by ldC, advanced by cntEn, complete when it reaches the exponent difference.
    always @(posedge clk) begin
        if (bus.ldC)        cnt <= 0;
        else if (bus.cntEn) cnt <= cnt + 1;
    end
    assign bus.complete = (cnt == dCur);

    typedef struct {
        int   d;
        logic ov;
        int   lat;
        int   shifts;
        logic sat;
    } vecT;

    vecT vecs [7];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        int groups;
        @(posedge clk);
        #1;
        groups = int'(bus.ldS1 | bus.ldS2 | bus.ldExp1 | bus.ldExp2 | bus.ldM1 | bus.ldM2)
               + int'(bus.ldRegA | bus.ldRegB | bus.ldC) + int'(bus.ldRegS) + int'(bus.ldFM);
        check("strobeExclusive", int'(groups <= 1), 1);
        check("shEnEqCntEn", int'(bus.shEn), int'(bus.cntEn));
        check("doneWithoutBusy", int'(bus.done && !bus.busy), 0);
    endtask

    function automatic int allOutputs();
        return int'({bus.ldS1, bus.ldS2, bus.ldExp1, bus.ldExp2, bus.ldM1, bus.ldM2,
                     bus.ldRegA, bus.ldRegB, bus.ldC, bus.shEn, bus.cntEn, bus.ldRegS,
                     bus.ldFM, bus.OV, bus.busy, bus.done, bus.alignSat});
    endfunction

    // Caller has already raised start (and ack for back-to-back); both are dropped after the first edge.
    task automatic waitDone(output int lat, output int shifts, output int ovNorm,
                            output int firstLoad, output int ovEarly);
        lat = 0; shifts = 0; ovNorm = -1; firstLoad = 0; ovEarly = 0;
        for (int n = 1; n <= 60; n++) begin
            step();
            bus.start = 1'b0;
            bus.ack   = 1'b0;
            if (n == 1) firstLoad = int'(bus.ldS1 && bus.ldM2 && bus.busy && !bus.done);
            if (bus.shEn) shifts++;
            if (bus.ldFM) ovNorm = int'(bus.OV);
            if (!bus.ldFM && !bus.done && bus.OV) ovEarly++;
            if (bus.done) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        int lat, shifts, ovNorm, firstLoad, ovEarly, sat;

        vecs[0] = '{d: 3,    ov: 1'b0, lat: 9,  shifts: 3,  sat: 1'b0};
        vecs[1] = '{d: 0,    ov: 1'b1, lat: 6,  shifts: 0,  sat: 1'b0};
        vecs[2] = '{d: 26,   ov: 1'b1, lat: 31, shifts: 26, sat: 1'b1};
        vecs[3] = '{d: 1,    ov: 1'b0, lat: 7,  shifts: 1,  sat: 1'b0};
        vecs[4] = '{d: 25,   ov: 1'b1, lat: 31, shifts: 25, sat: 1'b0};
        vecs[5] = '{d: 1000, ov: 1'b0, lat: 31, shifts: 26, sat: 1'b1};
        vecs[6] = '{d: 7,    ov: 1'b0, lat: 13, shifts: 7,  sat: 1'b0};

        total = 0; bad = 0;
        rst = 1'b1; dCur = 0;
        bus.start = 1'b0; bus.ack = 1'b0; bus.ovFlag = 1'b0;
        step();
        step();
        check("resetOutputs", allOutputs(), 0);
        rst = 1'b0;
        step();
        check("idleOutputs", allOutputs(), 0);

        foreach (vecs[i]) begin
            dCur = vecs[i].d;
            bus.ovFlag = vecs[i].ov;
            bus.start = 1'b1;
            waitDone(lat, shifts, ovNorm, firstLoad, ovEarly);
            sat = int'(bus.alignSat);
            check($sformatf("latency[%0d]", i), lat, vecs[i].lat);
            check($sformatf("shifts[%0d]", i), shifts, vecs[i].shifts);
            check($sformatf("alignSat[%0d]", i), sat, int'(vecs[i].sat));
            check($sformatf("ovNorm[%0d]", i), ovNorm, int'(vecs[i].ov));
            check($sformatf("loadFirst[%0d]", i), firstLoad, 1);
            check($sformatf("ovEarly[%0d]", i), ovEarly, 0);
            bus.ovFlag = ~vecs[i].ov;
            for (int h = 0; h < 3; h++) begin
                check($sformatf("doneHold[%0d]", i), int'(bus.done), 1);
                check($sformatf("ovHold[%0d]", i), int'(bus.OV), int'(vecs[i].ov));
                step();
            end
            bus.ack = 1'b1;
            step();
            bus.ack = 1'b0;
            check($sformatf("ackIdle[%0d]", i), int'({bus.done, bus.busy, bus.OV}), 0);
        end

        // Back-to-back: done held 5 cycles, then ack and start together.
        dCur = 3; bus.ovFlag = 1'b1; bus.start = 1'b1;
        waitDone(lat, shifts, ovNorm, firstLoad, ovEarly);
        check("b2bFirstLatency", lat, 9);
        bus.ovFlag = 1'b0;
        for (int h = 0; h < 5; h++) begin
            check("b2bDoneHeld", int'(bus.done && bus.OV), 1);
            if (h < 4) step();
        end
        dCur = 2; bus.ack = 1'b1; bus.start = 1'b1;
        waitDone(lat, shifts, ovNorm, firstLoad, ovEarly);
        check("b2bLoadNext", firstLoad, 1);
        check("b2bLatency", lat, 8);
        check("b2bOvCleared", int'(bus.OV), 0);
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        check("b2bIdle", int'(bus.busy), 0);

        // Reset mid-ALIGN, with stray start/ack ignored while busy.
        dCur = 20; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        bus.start = 1'b1; bus.ack = 1'b1;
        step();
        bus.start = 1'b0; bus.ack = 1'b0;
        check("strayIgnored", int'(bus.shEn && !bus.ldS1 && !bus.done), 1);
        rst = 1'b1;
        #1;
        check("noShiftInReset", int'(bus.shEn), 0);
        step();
        rst = 1'b0;
        check("midAlignReset", allOutputs(), 0);
        step();
        check("idleAfterReset", allOutputs(), 0);
        dCur = 2; bus.ovFlag = 1'b0; bus.start = 1'b1;
        waitDone(lat, shifts, ovNorm, firstLoad, ovEarly);
        check("rerunLatency", lat, 8);
        check("rerunShifts", shifts, 2);
        check("rerunSat", int'(bus.alignSat), 0);
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL globalTimeout actual=running required=finished");
        $fatal(1, "time limit");
    end

endmodule
